// File: rtl/binary_decoder_hold_pkg.sv
// Shared definitions for the binary codec blocks: state encoding and code/one-hot widths.
package binary_decoder_hold_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_decoder_hold_decoder.sv
// Combinational 3-to-8 decoder with enable; output is all-zero when disabled.
module decoder_3to8
    import binary_decoder_hold_pkg::*;
(
    input  logic                en,
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/binary_decoder_hold.sv
// Registered 3-to-8 decoder that holds each accepted code one-hot for HOLD_CYCLES,
// then drives GAP_CYCLES of all-zero before returning to idle.
module binary_decoder_hold
    import binary_decoder_hold_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN,
    input  logic [CODE_W-1:0]   Code,
    input  logic                Valid,
    output logic                Ready,
    output logic [ONEHOT_W-1:0] Out,
    output logic                Active,
    output logic                Last,
    output state_t              dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Handshake: a code is taken at a rising edge where Ready, EN and Valid are all high;
    // Valid in any other cycle is dropped without effect.
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CODE_W-1:0]   code_q, code_nxt;
    logic [ONEHOT_W-1:0] dec_onehot;
    logic                accept;

    assign accept    = Ready && EN && Valid;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                    code_nxt  = Code;
                end
            end
            ST_HOLD: begin
                // EN low takes priority over counter expiry.
                if (!EN) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!EN || cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decode the code that will be held next cycle so Out appears right after the accept edge.
    decoder_3to8 u_dec (
        .en     (state_nxt == ST_HOLD),
        .code   (code_nxt),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
            Ready  <= 1'b0;
            Out    <= '0;
            Active <= 1'b0;
            Last   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            Ready  <= (state_nxt == ST_IDLE);
            Out    <= dec_onehot;
            Active <= (state_nxt == ST_HOLD);
            Last   <= (state_nxt == ST_HOLD) && (cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_binary_decoder_hold.sv
// Bench for binary_decoder_hold: per-cycle reference plan model feeding an expected queue.
module tb_binary_decoder_hold;
    import binary_decoder_hold_pkg::*;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       EN;
    logic [2:0] Code;
    logic       Valid;
    logic       Ready;
    logic [7:0] Out;
    logic       Active;
    logic       Last;
    state_t     dbg_state;

    binary_decoder_hold #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .Code      (Code),
        .Valid     (Valid),
        .Ready     (Ready),
        .Out       (Out),
        .Active    (Active),
        .Last      (Last),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    endtask

    // reference model: {ready, active, last, out}
    logic [10:0] exp_q[$];
    logic [10:0] plan[$];
    logic        m_ready = 1'b0;

    always @(posedge clk) begin
        logic [10:0] nxt;
        cyc++;
        if (!rst_n) begin
            plan.delete();
            nxt = {1'b0, 1'b0, 1'b0, 8'h00};
        end else if (plan.size() != 0 && !EN) begin
            plan.delete();
            nxt = {1'b1, 1'b0, 1'b0, 8'h00};
        end else if (plan.size() != 0) begin
            nxt = plan.pop_front();
        end else if (m_ready && EN && Valid) begin
            for (int k = 0; k < HOLD; k++)
                plan.push_back({1'b0, 1'b1, (k == HOLD - 1), 8'h01 << Code});
            for (int k = 0; k < GAP; k++)
                plan.push_back({1'b0, 1'b0, 1'b0, 8'h00});
            nxt = plan.pop_front();
        end else begin
            nxt = {1'b1, 1'b0, 1'b0, 8'h00};
        end
        m_ready = nxt[10];
        exp_q.push_back(nxt);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [10:0] e;
        if (cyc > 0) begin
            if (exp_q.size() == 0) begin
                check("exp_queue_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out",    32'(Out),    32'(e[7:0]));
                check("active", 32'(Active), 32'(e[9]));
                check("last",   32'(Last),   32'(e[8]));
                check("ready",  32'(Ready),  32'(e[10]));
                check("onehot_or_zero", 32'($countones(Out) <= 1), 32'd1);
            end
        end
    end

    // driver tasks
    task automatic step(input logic en, input logic valid, input logic [2:0] code);
        EN    = en;
        Valid = valid;
        Code  = code;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 3'd0);
    endtask

    // lowest set bit wins, matching the upstream encoder (0100_1000 -> 3)
    function automatic logic [3:0] encode(input logic [7:0] in_v);
        logic [3:0] r;
        r = 4'd0;
        for (int b = 7; b >= 0; b--) if (in_v[b]) r = {1'b1, 3'(b)};
        return r;
    endfunction

    initial begin
        int last_acc;
        int waited;
        logic [3:0] enc;
        logic [7:0] enc_in;
        rst_n = 1'b0; EN = 1'b0; Valid = 1'b0; Code = 3'd0;
        last_acc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // single code, hold then gap
        step(1'b1, 1'b1, 3'd5);
        idle(8);

        // Valid during hold is ignored
        step(1'b1, 1'b1, 3'd5);
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 3'd2);
        step(1'b1, 1'b1, 3'd2);
        idle(6);

        // EN dropped in the 2nd hold cycle
        step(1'b1, 1'b1, 3'd1);
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        idle(3);

        // Valid held high, code stepping on each accept
        for (int i = 0; i < 8; i++) begin
            EN = 1'b1; Valid = 1'b1; Code = 3'(i);
            waited = 0;
            while (!Ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("accept_wait_timeout", 32'(waited < 20), 32'd1);
            if (i > 0) check("accept_spacing", 32'(cyc + 1 - last_acc), 32'd6);
            last_acc = cyc + 1;
            @(negedge clk);
        end
        Valid = 1'b0;
        idle(7);

        // priority-encoder loopback
        enc_in = 8'b0100_1000;
        enc = encode(enc_in);
        step(1'b1, enc[3], enc[2:0]);
        idle(6);
        enc_in = 8'h00;
        enc = encode(enc_in);
        step(1'b1, enc[3], enc[2:0]);
        idle(3);

        // reset in the middle of a hold
        step(1'b1, 1'b1, 3'd6);
        step(1'b1, 1'b0, 3'd0);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 3'd4);
        rst_n = 1'b1;
        idle(7);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
        end
        rst_n = 1'b1;
        idle(8);
        #1;
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
